// File: rtl/dram_reader_pkg.sv
// Shared types and AXI constants for the DRAM read master and its burst splitter.
package dram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR0  = 2'd1,
    AR1  = 2'd2,
    DATA = 2'd3
  } rd_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int BEAT_BYTES     = 16;
  localparam int BOUNDARY_BEATS = 256;

endpackage

// File: rtl/dram_burst_splitter.sv
// Splits a beat-aligned read into at most two INCR bursts so none crosses a 4 KB page.
module dram_burst_splitter
  import dram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 39
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  output logic [7:0]            burst0_len,
  output logic [ADDR_WIDTH-1:0] burst1_addr,
  output logic [7:0]            burst1_len,
  output logic                  split
);

  localparam logic [ADDR_WIDTH-13:0] PAGE_STEP = 1;

  logic [8:0] rem;
  logic       unused_addr_bits;

  // Beats left before the next 4 KB page; ranges 1..256.
  assign rem   = 9'(BOUNDARY_BEATS) - {1'b0, addr[11:4]};
  assign split = ({1'b0, len} > rem);

  // When split, rem < len <= 255, so rem fits in 8 bits.
  assign burst0_len  = split ? rem[7:0] : len;
  assign burst1_len  = split ? (len - rem[7:0]) : 8'd0;
  assign burst1_addr = {addr[ADDR_WIDTH-1:12] + PAGE_STEP, 12'h000};

  assign unused_addr_bits = ^addr[3:0];

endmodule

// File: rtl/dram_read_master.sv
// AXI4 read master: one request becomes one or two 4 KB-safe bursts, beats forwarded in order.
// Optional RRESP error flag is enabled by defining DRAM_READER_RRESP_CHECK_EN.
module dram_read_master
  import dram_reader_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int AXI_ID          = 0
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset_n,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_error,
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arid,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  // Handshakes: a transfer occurs on a rising clk_pixel edge where valid and ready are
  // both high; once arvalid rises, it and every AR field hold until that edge.

  rd_state_t                  state;
  rd_state_t                  state_next;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                 len_q;
  logic [8:0]                 beat_cnt;
  logic [8:0]                 beat_cnt_next;
  logic                       accept;
  logic                       r_hs;

  logic [7:0]                 burst0_len;
  logic [DRAM_ADDR_WIDTH-1:0] burst1_addr;
  logic [7:0]                 burst1_len;
  logic                       split;

  dram_burst_splitter #(
    .ADDR_WIDTH(DRAM_ADDR_WIDTH)
  ) u_splitter (
    .addr        (addr_q),
    .len         (len_q),
    .burst0_len  (burst0_len),
    .burst1_addr (burst1_addr),
    .burst1_len  (burst1_len),
    .split       (split)
  );

  assign accept        = (state == IDLE) && dram_read_en && (dram_read_len != 8'd0);
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign beat_cnt_next = beat_cnt + {8'd0, r_hs};

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= {dram_read_addr[DRAM_ADDR_WIDTH-1:4], 4'h0};
        len_q    <= dram_read_len;
        beat_cnt <= '0;
      end else if (r_hs) begin
        beat_cnt <= beat_cnt_next;
      end
    end
  end

  // R beats may already arrive while AR1 is pending; the counter runs in every busy state.
  always_comb begin
    state_next    = state;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = AR0;
      end
      AR0: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = addr_q;
        m_axi_arlen   = burst0_len - 8'd1;
        if (m_axi_arready) state_next = split ? AR1 : DATA;
      end
      AR1: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = burst1_addr;
        m_axi_arlen   = burst1_len - 8'd1;
        if (m_axi_arready) state_next = DATA;
      end
      DATA: begin
        if (beat_cnt_next == {1'b0, len_q}) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_axi_arsize   = SIZE_16B;
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arid     = 1'(AXI_ID);
  assign dram_read_busy = (state != IDLE);
  assign m_axi_rready   = dram_read_busy;

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      dram_read_data_valid <= 1'b0;
      dram_read_data       <= '0;
    end else begin
      dram_read_data_valid <= r_hs;
      if (r_hs) dram_read_data <= m_axi_rdata;
    end
  end

`ifdef DRAM_READER_RRESP_CHECK_EN
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_rlast, dram_read_addr[3:0]};

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      dram_read_error <= 1'b0;
    end else if (r_hs && (m_axi_rresp != RESP_OKAY)) begin
      dram_read_error <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs   = ^{m_axi_rlast, m_axi_rresp, dram_read_addr[3:0]};
  assign dram_read_error = 1'b0;
`endif

endmodule

// File: tb/tb_dram_read_master.sv
// Bench for dram_read_master: table of split vectors plus directed stall/ignore/RRESP/reset sequences.
module tb_dram_read_master;

  localparam int AW = 39;
  localparam int DW = 128;
`ifdef DRAM_READER_RRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          dram_reader_reset_n;
  logic [AW-1:0] dram_read_addr;
  logic [7:0]    dram_read_len;
  logic          dram_read_en;
  logic          dram_read_busy;
  logic [DW-1:0] dram_read_data;
  logic          dram_read_data_valid;
  logic          dram_read_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arid;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;

  dram_read_master dut (
    .clk_pixel            (clk),
    .dram_reader_reset_n  (dram_reader_reset_n),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_read_en         (dram_read_en),
    .dram_read_busy       (dram_read_busy),
    .dram_read_data       (dram_read_data),
    .dram_read_data_valid (dram_read_data_valid),
    .dram_read_error      (dram_read_error),
    .m_axi_araddr         (m_axi_araddr),
    .m_axi_arlen          (m_axi_arlen),
    .m_axi_arsize         (m_axi_arsize),
    .m_axi_arburst        (m_axi_arburst),
    .m_axi_arid           (m_axi_arid),
    .m_axi_arvalid        (m_axi_arvalid),
    .m_axi_arready        (m_axi_arready),
    .m_axi_rdata          (m_axi_rdata),
    .m_axi_rresp          (m_axi_rresp),
    .m_axi_rlast          (m_axi_rlast),
    .m_axi_rvalid         (m_axi_rvalid),
    .m_axi_rready         (m_axi_rready)
  );

  always #5 clk = ~clk;

  // Scoreboard and slave state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] r_q[$];
  logic          rl_q[$];
  logic [AW-1:0] ar_addr_q[$];
  logic [7:0]    ar_len_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            beats_seen = 0;
  int            r_sent = 0;
  int            err_beat = -1;
  int            ar_hold = 0;
  int            stall_cycles = 0;
  logic          stall_seen = 1'b0;
  logic          stall_bad = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  logic          r_gap = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic          split;
    logic [AW-1:0] a0;
    logic [7:0]    l0;
    logic [AW-1:0] a1;
    logic [7:0]    l1;
    logic          gap;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0], a[31:0], 32'h1234_0000 + a[31:0]};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive the slave for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (dram_read_data_valid) begin
      beats_seen++;
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else chk("beat_data", dram_read_data, exp_q.pop_front());
    end
    if (r_q.size() != 0 && !(r_gap && (cyc % 4 == 3))) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = r_q[0];
      m_axi_rlast  = rl_q[0];
      m_axi_rresp  = (r_sent == err_beat) ? 2'b10 : 2'b00;
      if (m_axi_rready) begin
        void'(r_q.pop_front());
        void'(rl_q.pop_front());
        r_sent++;
      end
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    if (m_axi_arvalid) begin
      if (ar_hold > 0) begin
        m_axi_arready = 1'b0;
        ar_hold--;
        stall_cycles++;
        if (stall_seen && m_axi_araddr !== stall_addr) stall_bad = 1'b1;
        stall_addr = m_axi_araddr;
        stall_seen = 1'b1;
      end else begin
        m_axi_arready = 1'b1;
        ar_addr_q.push_back(m_axi_araddr);
        ar_len_q.push_back(m_axi_arlen);
        chk("arsize", m_axi_arsize, 3'b100);
        chk("arburst", m_axi_arburst, 2'b01);
        chk("arid", m_axi_arid, 1'b0);
        for (int k = 0; k <= int'(m_axi_arlen); k++) begin
          r_q.push_back(pat(m_axi_araddr + AW'(16 * k)));
          rl_q.push_back(k == int'(m_axi_arlen));
        end
      end
    end else begin
      m_axi_arready = 1'b0;
    end
  endtask

  task automatic start_req(input logic [AW-1:0] addr, input logic [7:0] len);
    logic [AW-1:0] base;
    base = {addr[AW-1:4], 4'h0};
    dram_read_addr = addr;
    dram_read_len  = len;
    dram_read_en   = 1'b1;
    ar_addr_q.delete();
    ar_len_q.delete();
    beats_seen = 0;
    r_sent     = 0;
    for (int i = 0; i < int'(len); i++) exp_q.push_back(pat(base + AW'(16 * i)));
    tick();
    dram_read_en = 1'b0;
    if (len != 8'd0) chk("busy_rise", dram_read_busy, 1'b1);
  endtask

  task automatic wait_idle(input int len);
    int n;
    n = 0;
    while (dram_read_busy && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", dram_read_busy, 1'b0);
    chk("beat_count", beats_seen, len);
    chk("last_beat_with_busy_fall", dram_read_data_valid, 1'b1);
    chk("exp_q_drained", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, dram_read_busy, 1'b0);
    chk({tag, "_valid"}, dram_read_data_valid, 1'b0);
    chk({tag, "_data"}, dram_read_data, '0);
    chk({tag, "_error"}, dram_read_error, 1'b0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    chk({tag, "_rready"}, m_axi_rready, 1'b0);
    chk({tag, "_araddr"}, m_axi_araddr, '0);
    chk({tag, "_arlen"}, m_axi_arlen, '0);
  endtask

  initial begin
    vecs[0] = '{39'h1000, 8'd100, 1'b0, 39'h1000, 8'd99, 39'h0, 8'd0, 1'b0};
    vecs[1] = '{39'h1F00, 8'd113, 1'b1, 39'h1F00, 8'd15, 39'h2000, 8'd96, 1'b0};
    vecs[2] = '{39'h1FF7, 8'd1, 1'b0, 39'h1FF0, 8'd0, 39'h0, 8'd0, 1'b0};
    vecs[3] = '{39'h1F00, 8'd16, 1'b0, 39'h1F00, 8'd15, 39'h0, 8'd0, 1'b1};
    vecs[4] = '{39'h1F00, 8'd17, 1'b1, 39'h1F00, 8'd15, 39'h2000, 8'd0, 1'b0};
    vecs[5] = '{39'h0, 8'd255, 1'b0, 39'h0, 8'd254, 39'h0, 8'd0, 1'b1};
    vecs[6] = '{39'h3FF0, 8'd2, 1'b1, 39'h3FF0, 8'd0, 39'h4000, 8'd0, 1'b0};
    vecs[7] = '{39'h12_3456_7F80, 8'd200, 1'b1, 39'h12_3456_7F80, 8'd7, 39'h12_3456_8000, 8'd191, 1'b1};
    vecs[8] = '{39'h0800, 8'd255, 1'b1, 39'h0800, 8'd127, 39'h1000, 8'd126, 1'b0};

    dram_reader_reset_n = 1'b0;
    dram_read_addr = '0;
    dram_read_len  = '0;
    dram_read_en   = 1'b0;
    m_axi_arready  = 1'b0;
    m_axi_rdata    = '0;
    m_axi_rresp    = 2'b00;
    m_axi_rlast    = 1'b0;
    m_axi_rvalid   = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    dram_reader_reset_n = 1'b1;
    tick();

    // Table: single and split bursts, issued back to back as soon as busy drops
    foreach (vecs[i]) begin
      r_gap = vecs[i].gap;
      start_req(vecs[i].addr, vecs[i].len);
      wait_idle(int'(vecs[i].len));
      chk("ar_count", ar_addr_q.size(), vecs[i].split ? 2 : 1);
      if (ar_addr_q.size() >= 1) begin
        chk("ar0_addr", ar_addr_q[0], vecs[i].a0);
        chk("ar0_len", ar_len_q[0], vecs[i].l0);
      end
      if (vecs[i].split && ar_addr_q.size() >= 2) begin
        chk("ar1_addr", ar_addr_q[1], vecs[i].a1);
        chk("ar1_len", ar_len_q[1], vecs[i].l1);
      end
    end
    r_gap = 1'b0;

    // Request strobe while busy is ignored
    start_req(39'h3000, 8'd40);
    repeat (5) tick();
    dram_read_addr = 39'h7000;
    dram_read_len  = 8'd5;
    dram_read_en   = 1'b1;
    tick();
    dram_read_en = 1'b0;
    chk("busy_hold_on_ignored", dram_read_busy, 1'b1);
    wait_idle(40);
    chk("ignored_ar_count", ar_addr_q.size(), 1);

    // len=0 while idle is a no-op
    tick();
    ar_addr_q.delete();
    dram_read_addr = 39'h4000;
    dram_read_len  = 8'd0;
    dram_read_en   = 1'b1;
    tick();
    dram_read_en = 1'b0;
    tick();
    chk("len0_busy", dram_read_busy, 1'b0);
    chk("len0_arvalid", m_axi_arvalid, 1'b0);
    tick();
    chk("len0_ar_count", ar_addr_q.size(), 0);

    // AR stall: arready low for 7 cycles
    ar_hold      = 7;
    stall_seen   = 1'b0;
    stall_bad    = 1'b0;
    stall_cycles = 0;
    start_req(39'h6040, 8'd30);
    wait_idle(30);
    chk("stall_cycles", stall_cycles, 7);
    chk("stall_addr_stable", stall_bad, 1'b0);
    chk("stall_addr", stall_addr, 39'h6040);
    chk("stall_ar_count", ar_addr_q.size(), 1);

    // RRESP error on beat 5, then a clean request to show stickiness
    chk("error_before", dram_read_error, 1'b0);
    err_beat = 4;
    start_req(39'h2000, 8'd20);
    wait_idle(20);
    chk("error_set", dram_read_error, EXP_ERR);
    err_beat = -1;
    start_req(39'h2400, 8'd8);
    wait_idle(8);
    chk("error_sticky", dram_read_error, EXP_ERR);

    // Reset during beat 50 of 100
    begin
      int n;
      start_req(39'h9000, 8'd100);
      n = 0;
      while (beats_seen < 50 && n < 1000) begin
        tick();
        n++;
      end
      chk("reached_beat50", beats_seen, 50);
      dram_reader_reset_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      tick();
      dram_reader_reset_n = 1'b1;
      exp_q.delete();
      repeat (5) tick();
      chk("post_rst_busy", dram_read_busy, 1'b0);
      chk("post_rst_rready", m_axi_rready, 1'b0);
      r_q.delete();
      rl_q.delete();
      tick();
    end
    start_req(39'h5000, 8'd10);
    wait_idle(10);
    chk("post_rst_ar_addr", (ar_addr_q.size() >= 1) ? ar_addr_q[0] : '1, 39'h5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_read_master.md
DRAM_READ_MASTER -- requirements
Module: dram_read_master

Interface
REQ-001 SHALL be decided as: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter DRAM_ADDR_WIDTH, default 39: byte address width.
REQ-003 SHALL have parameter DRAM_DATA_WIDTH, default 128: data and beat width; beat size is 16 B.
REQ-004 SHALL have parameter AXI_ID, default 0: constant ARID.
REQ-005 SHALL have these ports:
- clk_pixel  in  1  sole clock
- dram_reader_reset_n  in  1  async active-low reset
- dram_read_addr  in  DRAM_ADDR_WIDTH  request byte address
- dram_read_len  in  8  beat count; 0 = no-op
- dram_read_en  in  1  one-cycle request strobe
- dram_read_busy  out  1  request in progress
- dram_read_data  out  DRAM_DATA_WIDTH  beat data
- dram_read_data_valid  out  1  beat strobe
- dram_read_error  out  1  sticky RRESP error
- m_axi_araddr/arlen/arsize/arburst/arid/arvalid  out  DRAM_ADDR_WIDTH/8/3/2/1/1  AXI4 AR
- m_axi_arready  in  1
- m_axi_rdata/rresp/rlast/rvalid  in  DRAM_DATA_WIDTH/2/1/1  AXI4 R
- m_axi_rready  out  1

Function
REQ-006 SHALL accept a request only when dram_read_en=1, busy=0 and len!=0; it SHALL latch the address with bits [3:0] forced to 0 and latch len.
REQ-007 SHALL silently ignore dram_read_en while busy=1 or when len=0; busy SHALL not rise for len=0.
REQ-008 SHALL raise busy on the cycle after acceptance and hold it until the cycle after the final R beat of the request.
REQ-009 SHALL use FSM states IDLE->AR0->(AR1 if split)->DATA->IDLE.
REQ-010 SHALL never let a burst cross a 4 KB boundary: rem = 256 - addr[11:4]; if len>rem, burst0 = rem beats and burst1 = len-rem beats at the next 4 KB base, otherwise a single burst.
REQ-011 SHALL drive ARLEN = beats-1, ARSIZE = 3'b100, ARBURST = INCR (2'b01) and ARID = AXI_ID.
REQ-012 SHALL hold ARVALID and all AR fields stable until ARREADY is sampled; AR1 SHALL issue after the AR0 handshake without waiting for R data.
REQ-013 SHALL hold m_axi_rready=1 whenever busy=1 and 0 in IDLE; downstream backpressure is the consumer's prog_full responsibility.
REQ-014 SHALL register each R handshake beat onto dram_read_data with dram_read_data_valid=1 for exactly one cycle, one cycle after the handshake, in arrival order.
REQ-015 SHALL count received beats in a 9-bit counter and leave DATA when count equals len; RLAST SHALL be ignored for completion.
REQ-016 SHALL allow a new request to be accepted on the first cycle busy=0, i.e. back-to-back requests separated by one idle cycle.

Reset
REQ-017 SHALL drive, while dram_reader_reset_n=0: busy=0, data_valid=0, data=0, error=0, arvalid=0, rready=0, araddr=0, arlen=0, FSM=IDLE and beat counter=0.
REQ-018 SHALL, on reset asserted mid-burst, abandon the transaction immediately; outstanding R beats after release are not forwarded because rready=0 in IDLE.

Configuration
REQ-019 SHALL, with DRAM_READER_RRESP_CHECK_EN defined, set dram_read_error sticky on any beat with RRESP!=OKAY, cleared only by reset, with data still forwarded unchanged.
REQ-020 SHALL, without DRAM_READER_RRESP_CHECK_EN, tie dram_read_error to 0 and ignore RRESP.

Structure
REQ-021 SHALL place the FSM state enum, AXI constants (BURST_INCR, SIZE_16B, RESP_OKAY) and the BEAT_BYTES=16 and BOUNDARY_BEATS=256 constants in package dram_reader_pkg.
REQ-022 SHALL implement the split arithmetic of REQ-010 in sub-module dram_burst_splitter (addr, len -> burst0 len, burst1 addr, burst1 len, split flag).

Verification
REQ-023 SHALL cover single burst: addr=0x1000, len=100, arready=1 -> one AR with araddr=0x1000 and arlen=99; 100 valid beats; busy falls after beat 100.
REQ-024 SHALL cover split: addr=0x1F00, len=113 -> AR0 with araddr=0x1F00 and arlen=15; AR1 with araddr=0x2000 and arlen=96; 113 beats delivered.
REQ-025 SHALL cover ignored requests: en during busy, and len=0 while idle -> no AR issued and busy unchanged.
REQ-026 SHALL cover AR stall: arready held low for 7 cycles -> arvalid and araddr stable throughout; exactly one handshake.
REQ-027 SHALL cover RRESP: beat 5 returns SLVERR -> error=1 and sticky with the macro defined; error=0 with it undefined.
REQ-028 SHALL cover reset during beat 50 of 100 -> all outputs at reset values; a later request completes normally.
